// File: rtl/mac_seq_ctrl_if.sv
// mac_seq_ctrl_if: operand-in / result-out handshake bundle for the MAC sequencer.
interface mac_seq_ctrl_if #(parameter int OP_W = 10, parameter int ACC_W = 20);
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] in_a;
  logic [OP_W-1:0] in_b;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [ACC_W-1:0] out_acc;
  logic            out_ovf;
  logic            busy;
  modport master (output in_valid, in_a, in_b, in_last, out_ready,
                  input in_ready, out_valid, out_acc, out_ovf, busy);
  modport slave  (input in_valid, in_a, in_b, in_last, out_ready,
                  output in_ready, out_valid, out_acc, out_ovf, busy);
endinterface

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: shift-add dot-product sequencer sharing one ACC_W adder.
// Define MAC_SAT_EN for a saturating accumulator; otherwise it wraps.
module mac_seq_ctrl #(
  parameter int OP_W  = 10,
  parameter int ACC_W = 20,
  parameter int CNT_W = 4
) (
  input logic         clk,
  input logic         rst_n,
  mac_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;
  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, prod_q, prod_d, mcand_q, mcand_d;
  logic [ACC_W-1:0] add_a, add_b, sum;
  logic [OP_W-1:0]  mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d, ovf_q, ovf_d, wrap;
  logic             in_ready_q, out_valid_q, busy_q;

  always_comb begin
    add_a    = state_q == ACC ? acc_q : prod_q;
    add_b    = state_q == ACC ? prod_q : (mplier_q[0] ? mcand_q : '0);
    sum      = add_a + add_b;
    wrap     = sum < acc_q;
    state_d  = state_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: if (bus.in_valid && in_ready_q) begin
        mcand_d  = {{(ACC_W-OP_W){1'b0}}, bus.in_a};
        mplier_d = bus.in_b;
        last_d   = bus.in_last;
        prod_d   = '0;
        cnt_d    = '0;
        state_d  = MUL;
      end
      MUL: begin
        prod_d   = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        state_d  = cnt_q == CNT_W'(OP_W-1) ? ACC : MUL;
      end
      ACC: begin
`ifdef MAC_SAT_EN
        acc_d = wrap ? '1 : sum;
`else
        acc_d = sum;
`endif
        ovf_d   = ovf_q | wrap;
        state_d = last_q ? DONE : IDLE;
      end
      DONE: if (bus.out_ready) begin
        acc_d   = '0;
        ovf_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // handshake outputs are registered from the next state so they track state_q exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      prod_q      <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= state_d == IDLE;
      out_valid_q <= state_d == DONE;
      busy_q      <= state_d != IDLE;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = acc_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: directed vectors with hand-computed dot products.
module tb_mac_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int n;
  logic [31:0] held;
`ifdef MAC_SAT_EN
  localparam int OVF_ACC = 1048575;
`else
  localparam int OVF_ACC = 1044482;
`endif

  mac_seq_ctrl_if #(.OP_W(10), .ACC_W(20)) bus ();
  mac_seq_ctrl #(.OP_W(10), .ACC_W(20), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!bus.in_ready && cyc < 50) begin
      cyc++;
      tick();
    end
  endtask

  task automatic send(input int a, input int b, input logic last);
    int w;
    wait_ready(w);
    if (w >= 50) chk("send_timeout", 0, 1);
    bus.in_a = 10'(a);
    bus.in_b = 10'(b);
    bus.in_last = last;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_a = 10'h155;
    bus.in_b = 10'h2aa;
  endtask

  task automatic get(input string tag, input int exp_acc, input logic exp_ovf);
    int w = 0;
    while (!bus.out_valid && w < 50) begin
      w++;
      tick();
    end
    if (w >= 50) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_acc"}, bus.out_acc, exp_acc);
    chk({tag, "_ovf"}, bus.out_ovf, exp_ovf);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_acc", bus.out_acc, 0);
    chk("rst_out_ovf", bus.out_ovf, 0);
    chk("rst_busy", bus.busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // reset in the middle of a multiply
    send(3, 5, 1'b1);
    repeat (4) tick();
    chk("mid_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_out_valid", bus.out_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    send(3, 5, 1'b1);
    get("after_rst", 15, 1'b0);

    // latency: out_valid first seen after the 11th edge following accept
    send(3, 5, 1'b1);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.out_valid) begin
        n = i;
        break;
      end
    end
    chk("latency", n, 11);
    get("lat", 15, 1'b0);

    // dot product with in_ready low for 11 cycles per term
    send(2, 7, 1'b0);
    wait_ready(n);
    chk("dp_busy1", n, 11);
    chk("dp_nv1", bus.out_valid, 0);
    send(10, 10, 1'b0);
    wait_ready(n);
    chk("dp_busy2", n, 11);
    chk("dp_nv2", bus.out_valid, 0);
    send(1023, 1, 1'b1);
    get("dot", 1137, 1'b0);

    // overflow, then backpressure in DONE
    send(1023, 1023, 1'b0);
    send(1023, 1023, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      n++;
      tick();
    end
    held = bus.out_acc;
    chk("ovf_acc", held, OVF_ACC);
    chk("ovf_flag", bus.out_ovf, 1);
    bus.in_a = 10'd7;
    bus.in_b = 10'd7;
    bus.in_last = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_acc", bus.out_acc, held);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_valid", bus.out_valid, 1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_release", bus.out_valid, 0);
    send(1, 1, 1'b1);
    get("post_ovf", 1, 1'b0);

    // zero and edge operands
    send(0, 1023, 1'b0);
    send(1023, 0, 1'b1);
    get("zero", 0, 1'b0);
    send(1, 512, 1'b1);
    get("msb", 512, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
